rr_arb8: RTL and testbench
==========================

Name: rr_arb8

Overview:
- Round-robin arbiter that shares one 8-input priority-encode resource among 8 requesters.
- Uses a rotating-priority encoder to pick a winner. Registers a one-hot grant plus its 3-bit index and a valid flag (Ys-style indicator).
- Holds the grant until the owner releases it, then rotates priority to prevent starvation.
- Sits between requester agents and the shared encoder/seg-display path.

Parameters:
- N, 8, number of requesters (fixed at 8 in this revision).
- IDX_W, 3, width of grant index, equal to clog2(N).
- MAX_HOLD, 16, grant timeout in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbiter enable. Low forces idle.
- req  in  8  request vector; bit i belongs to requester i.
- done  in  8  release pulses; bit i is honoured only while i is granted.
- gnt  out  8  one-hot grant, registered.
- gnt_idx  out  3  binary index of the granted requester, registered.
- gnt_valid  out  1  high while a grant is held, registered.
- timeout  out  1  one-cycle pulse on forced revoke. Present only with ARB_TIMEOUT_EN.

Behaviour:
- One clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=3'd0, state=IDLE.
- Reset may assert mid-grant; the grant drops immediately (asynchronous).
- ptr (3 bits) is the highest-priority requester for the next arbitration.
  - Winner = first set bit of req scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
- IDLE state:
  - If en=1 and req≠0: load gnt=1<<w, gnt_idx=w, gnt_valid=1 and go to GRANT.
  - Latency is 1 cycle: req sampled at edge t, gnt visible after edge t.
  - If req=0: stay in IDLE with outputs 0.
- GRANT state:
  - Hold gnt/gnt_idx stable regardless of other req changes.
  - Release condition: done[gnt_idx]=1 OR req[gnt_idx]=0, sampled at an edge.
  - On release: gnt=0, gnt_valid=0, gnt_idx keeps its last value, ptr=gnt_idx+1 (3-bit wrap, 7→0), go to IDLE.
  - A release costs exactly one bubble cycle before the next grant.
- done bits for non-granted indices are ignored in every state. done and a req drop in the same cycle count as a single release.
- en=0 in any state:
  - Next edge: gnt=0, gnt_valid=0, state=IDLE.
  - ptr is unchanged; a revoke by en does not rotate.
- No grant is ever issued with req=0. gnt is always one-hot or zero.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches MAX_HOLD-1 with no release in that cycle, the next edge forcibly releases the grant.
  - The forced release rotates ptr exactly like a normal release and pulses timeout=1 for one cycle.
  - A normal release in the same cycle takes precedence: no timeout pulse.
- Undefined: no counter, no timeout port. The grant is held indefinitely until release.

Decomposition:
- Package arb_pkg: N, IDX_W, MAX_HOLD default, state enum {IDLE, GRANT}.
- Sub-module rot_prio_enc: combinational.
  - Inputs: req[7:0], ptr[2:0]. Outputs: idx[2:0], any.
  - Implementation: rotate req right by ptr, apply a fixed 8→3 priority encode with bit 0 highest, add ptr back mod 8.
- rr_arb8 holds the FSM, ptr, output registers and the optional counter.

Test Plan:
- Reset, then en=1, req=8'b0000_0101 → after 1 edge: gnt=8'h01, gnt_idx=0, gnt_valid=1. Pulse done[0] → next edge gnt=0. Following edge: gnt=8'h04, gnt_idx=2 (ptr=1 skips 0).
- All 8 requesting continuously, each grant released by done after 1 cycle → grant order 0,1,2,…,7,0 with one bubble between each. Confirms ptr wraps 7→0.
- In GRANT on idx 3: pulse done[5] and toggle req[6] → gnt stays 8'h08. Drop req[3] → released next edge, ptr=4.
- Grant idx 2 held, en=0 → next edge gnt=0, state IDLE. en=1 with req=8'h04 → idx 2 regranted (ptr still 0).
- Assert rst asynchronously mid-GRANT → gnt=0, gnt_valid=0, gnt_idx=0 immediately, ptr=0. After release of rst with req=8'h80 → gnt=8'h80, gnt_idx=7.
- ARB_TIMEOUT_EN defined, MAX_HOLD=16, req[1] held with no done → gnt=8'h02 for exactly 16 cycles, then timeout=1 for one cycle and gnt=0. Next grant goes to idx 1 again if it is the only requester.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the rr_arb8 round-robin arbiter
package arb_pkg;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rot_prio_enc.sv
// rtl/rot_prio_enc.sv - rotating-priority 8-to-3 encoder, ptr marks the highest-priority input
module rot_prio_enc
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] enc;

    // Rotate right by ptr so the preferred requester lands on bit 0, encode, then undo the rotation
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N-1:0];
        enc     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                enc = IDX_W'(i);
            end
        end
        idx = enc + ptr;
        any = |req;
    end

endmodule

// File: rtl/rr_arb8.sv
// rtl/rr_arb8.sv - 8-way round-robin arbiter with held grants; ARB_TIMEOUT_EN adds a forced-release timer
module rr_arb8
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
`ifdef ARB_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             gnt_valid
);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [N-1:0]     gnt_n;
    logic [IDX_W-1:0] gnt_idx_n;
    logic             gnt_valid_n;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             release_now;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]       hold_cnt, hold_cnt_n;
    logic             timeout_n;
`endif

    rot_prio_enc u_enc (
        .req (req),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    // Owner gives up the grant by pulsing its done bit or by dropping its request
    assign release_now = done[gnt_idx] | ~req[gnt_idx];

    // State, pointer and registered outputs; reset drops any live grant at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gnt       <= gnt_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= gnt_valid_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt_n;
            timeout   <= timeout_n;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE, hold in GRANT, rotate ptr past the owner on release
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        gnt_n       = gnt;
        gnt_idx_n   = gnt_idx;
        gnt_valid_n = gnt_valid;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n  = hold_cnt;
        timeout_n   = 1'b0;
`endif
        if (!en) begin
            // Revoke by enable leaves ptr alone so the same requester keeps its turn
            state_n     = IDLE;
            gnt_n       = '0;
            gnt_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state_n     = GRANT;
                        gnt_n       = N'(1) << win_idx;
                        gnt_idx_n   = win_idx;
                        gnt_valid_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_n  = '0;
`endif
                    end else begin
                        gnt_n       = '0;
                        gnt_valid_n = 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_n     = IDLE;
                        gnt_n       = '0;
                        gnt_valid_n = 1'b0;
                        ptr_n       = gnt_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
                        state_n     = IDLE;
                        gnt_n       = '0;
                        gnt_valid_n = 1'b0;
                        ptr_n       = gnt_idx + 1'b1;
                        timeout_n   = 1'b1;
                    end else begin
                        hold_cnt_n  = hold_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// tb/tb_rr_arb8.sv - directed self-checking bench for rr_arb8 (timeout checks follow ARB_TIMEOUT_EN)
module tb_rr_arb8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int passed;
    int total;

    rr_arb8 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
`ifdef ARB_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b1;
        req  = 8'h00;
        done = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 8'h00;
        step();
        step();
        total++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0)
            $display("FAIL reset_state: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req = 8'b0000_0101;
        step();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1)
            $display("FAIL basic_first: gnt=%h idx=%0d valid=%b, want 01/0/1", gnt, gnt_idx, gnt_valid);
        else passed++;
        done = 8'h01;
        step();
        done = 8'h00;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0)
            $display("FAIL basic_release: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
        else passed++;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1)
            $display("FAIL basic_second: gnt=%h idx=%0d valid=%b, want 04/2/1", gnt, gnt_idx, gnt_valid);
        else passed++;
        req = 8'h00;
        step();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0)
            $display("FAIL basic_reqdrop: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
        else passed++;
        step();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0)
            $display("FAIL basic_idle_noreq: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_gnt;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_gnt = 8'h01 << (k % 8);
            step();
            total++;
            if (gnt !== exp_gnt || gnt_idx !== 3'(k % 8) || gnt_valid !== 1'b1)
                $display("FAIL rr_grant_%0d: gnt=%h idx=%0d, want %h/%0d", k, gnt, gnt_idx, exp_gnt, k % 8);
            else passed++;
            done = exp_gnt;
            step();
            done = 8'h00;
            total++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0)
                $display("FAIL rr_bubble_%0d: gnt=%h valid=%b, want 00/0", k, gnt, gnt_valid);
            else passed++;
        end
        req = 8'h00;
    endtask

    task automatic test_hold();
        do_reset();
        req = 8'h08;
        step();
        total++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3)
            $display("FAIL hold_grant: gnt=%h idx=%0d, want 08/3", gnt, gnt_idx);
        else passed++;
        done = 8'h20;
        req  = 8'h48;
        step();
        total++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1)
            $display("FAIL hold_foreign_done: gnt=%h idx=%0d, want 08/3", gnt, gnt_idx);
        else passed++;
        done = 8'h00;
        req  = 8'h08;
        step();
        total++;
        if (gnt !== 8'h08)
            $display("FAIL hold_stable: gnt=%h, want 08", gnt);
        else passed++;
        req = 8'h00;
        step();
        total++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd3)
            $display("FAIL hold_release: gnt=%h idx=%0d, want 00/3", gnt, gnt_idx);
        else passed++;
        // ptr should now be 4: bits 0,3,4 requesting -> 4 wins
        req = 8'h19;
        step();
        total++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4)
            $display("FAIL hold_ptr4: gnt=%h idx=%0d, want 10/4", gnt, gnt_idx);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_enable();
        do_reset();
        req = 8'h04;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2)
            $display("FAIL en_grant: gnt=%h idx=%0d, want 04/2", gnt, gnt_idx);
        else passed++;
        en = 1'b0;
        step();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd2)
            $display("FAIL en_revoke: gnt=%h idx=%0d valid=%b, want 00/2/0", gnt, gnt_idx, gnt_valid);
        else passed++;
        step();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0)
            $display("FAIL en_idle: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
        else passed++;
        // ptr still 0: with bits 2,3 requesting, 2 wins (3 would win had ptr rotated)
        en  = 1'b1;
        req = 8'h0C;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2)
            $display("FAIL en_regrant: gnt=%h idx=%0d, want 04/2", gnt, gnt_idx);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_same_cycle_release();
        do_reset();
        req = 8'h02;
        step();
        done = 8'h02;
        req  = 8'h00;
        step();
        done = 8'h00;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0)
            $display("FAIL dual_release: gnt=%h valid=%b, want 00/0", gnt, gnt_valid);
        else passed++;
        // single rotation -> ptr=2, so of bits 1,2 the 2 wins
        req = 8'h06;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2)
            $display("FAIL dual_ptr: gnt=%h idx=%0d, want 04/2", gnt, gnt_idx);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h04;
        step();
        req = 8'h00;
        step();
        req = 8'h04;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2)
            $display("FAIL ar_pre: gnt=%h idx=%0d, want 04/2", gnt, gnt_idx);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0)
            $display("FAIL ar_immediate: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
        else passed++;
        step();
        rst = 1'b0;
        // ptr back to 0: of bits 0 and 7, 0 wins
        req = 8'h81;
        step();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0)
            $display("FAIL ar_ptr0: gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
        else passed++;
        req = 8'h80;
        step();
        step();
        total++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7 || gnt_valid !== 1'b1)
            $display("FAIL ar_grant7: gnt=%h idx=%0d, want 80/7", gnt, gnt_idx);
        else passed++;
        req = 8'h00;
        step();
    endtask

    task automatic test_long_hold();
        do_reset();
        req = 8'h02;
        step();
`ifdef ARB_TIMEOUT_EN
        total++;
        if (gnt !== 8'h02 || timeout !== 1'b0)
            $display("FAIL to_first: gnt=%h timeout=%b, want 02/0", gnt, timeout);
        else passed++;
        for (int c = 2; c <= 16; c++) begin
            step();
            total++;
            if (gnt !== 8'h02 || timeout !== 1'b0)
                $display("FAIL to_hold_%0d: gnt=%h timeout=%b, want 02/0", c, gnt, timeout);
            else passed++;
        end
        step();
        total++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_valid !== 1'b0)
            $display("FAIL to_fire: gnt=%h timeout=%b valid=%b, want 00/1/0", gnt, timeout, gnt_valid);
        else passed++;
        step();
        total++;
        if (gnt !== 8'h02 || gnt_idx !== 3'd1 || timeout !== 1'b0)
            $display("FAIL to_regrant: gnt=%h idx=%0d timeout=%b, want 02/1/0", gnt, gnt_idx, timeout);
        else passed++;
`else
        for (int c = 2; c <= 40; c++) begin
            step();
            total++;
            if (gnt !== 8'h02 || gnt_valid !== 1'b1)
                $display("FAIL hold_forever_%0d: gnt=%h valid=%b, want 02/1", c, gnt, gnt_valid);
            else passed++;
        end
`endif
        req = 8'h00;
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        en     = 1'b0;
        req    = 8'h00;
        done   = 8'h00;
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_enable();
        test_same_cycle_release();
        test_async_reset();
        test_long_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
